cache_victim_wbbuf: RTL and testbench

- Single-entry victim writeback buffer on the eviction side of the cache.
- Captures a dirty line from the way chosen by the replacement policy (one-hot victim way, line address, line data) and drains it to the bus as sequential beats with a per-beat handshake.
- Provides an address-match lookup so the cache can stall a refill or access that targets the line still in flight.

---
 rtl/cache_victim_wbbuf.sv | 110 +++++++++++
 tb/tb_cache_victim_wbbuf.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_wbbuf.sv
// Single-entry victim writeback buffer: captures one dirty line and drains it as bus beats.
// Also answers address lookups so the cache can stall accesses to a line still in flight.
module cache_victim_wbbuf #(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64,
    parameter int PA_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EvictValid,
    output logic               EvictReady,
    input  logic [NUMWAYS-1:0] EvictWay,
    input  logic [PA_BITS-1:0] EvictAdr,
    input  logic [LINELEN-1:0] EvictLine,
    output logic               BusReq,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWData,
    output logic               BusLast,
    input  logic               BusBeatAck,
    input  logic [PA_BITS-1:0] LookupAdr,
    output logic               LookupHit,
    output logic [NUMWAYS-1:0] HeldWay,
    output logic               WbDone
);

    localparam int BEATS     = LINELEN / BEATLEN;
    localparam int BEATCNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFLEN    = $clog2(LINELEN / 8);
    localparam int BEATBYTES = BEATLEN / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [BEATCNTW-1:0] LAST_BEAT = BEATCNTW'(BEATS - 1);

    logic [0:0]                      state_q, state_d;
    logic [BEATCNTW-1:0]             cnt_q, cnt_d;
    logic [PA_BITS-1:0]              adr_q, adr_d;
    logic [BEATS-1:0][BEATLEN-1:0]   line_q, line_d;
    logic [NUMWAYS-1:0]              way_q, way_d;

    logic draining;
    logic last_beat;
    logic beat_ack;
    logic capture;

    assign draining  = (state_q == DRAIN);
    assign last_beat = (cnt_q == LAST_BEAT);
    // Acks outside DRAIN are meaningless and must not move the counter.
    assign beat_ack  = draining && BusBeatAck;
    assign capture   = (state_q == IDLE) && EvictValid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        line_d  = line_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    adr_d   = {EvictAdr[PA_BITS-1:OFFLEN], {OFFLEN{1'b0}}};
                    line_d  = EvictLine;
                    way_d   = EvictWay;
                end
            end
            DRAIN: begin
                if (beat_ack) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            line_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            line_q  <= line_d;
            way_q   <= way_d;
        end
    end

    // Ready comes purely from state so a finishing line always leaves one idle cycle.
    assign EvictReady = (state_q == IDLE);
    assign BusReq     = draining;
    assign BusLast    = draining && last_beat;
    assign BusWData   = line_q[cnt_q];
    assign BusAdr     = adr_q + (PA_BITS'(cnt_q) * PA_BITS'(BEATBYTES));
    assign WbDone     = beat_ack && last_beat;
    assign HeldWay    = way_q;
    assign LookupHit  = draining && (LookupAdr[PA_BITS-1:OFFLEN] == adr_q[PA_BITS-1:OFFLEN]);

endmodule

// File: tb/tb_cache_victim_wbbuf.sv
// Randomized scoreboard bench for cache_victim_wbbuf: the driver queues expected beats for every
// accepted eviction and a negedge monitor compares each presented beat against the queue head.
module tb_cache_victim_wbbuf;

    logic         clk;
    logic         reset;
    logic         EvictValid;
    logic         EvictReady;
    logic [3:0]   EvictWay;
    logic [31:0]  EvictAdr;
    logic [255:0] EvictLine;
    logic         BusReq;
    logic [31:0]  BusAdr;
    logic [63:0]  BusWData;
    logic         BusLast;
    logic         BusBeatAck;
    logic [31:0]  LookupAdr;
    logic         LookupHit;
    logic [3:0]   HeldWay;
    logic         WbDone;

    cache_victim_wbbuf #(
        .NUMWAYS(4),
        .LINELEN(256),
        .BEATLEN(64),
        .PA_BITS(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .EvictValid (EvictValid),
        .EvictReady (EvictReady),
        .EvictWay   (EvictWay),
        .EvictAdr   (EvictAdr),
        .EvictLine  (EvictLine),
        .BusReq     (BusReq),
        .BusAdr     (BusAdr),
        .BusWData   (BusWData),
        .BusLast    (BusLast),
        .BusBeatAck (BusBeatAck),
        .LookupAdr  (LookupAdr),
        .LookupHit  (LookupHit),
        .HeldWay    (HeldWay),
        .WbDone     (WbDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] base;
        logic [63:0] data;
        logic        last;
        logic [3:0]  way;
    } beat_t;

    beat_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;
    bit in_reset = 1'b1;

    bit           cap_pending = 1'b0;
    logic [31:0]  cap_adr;
    logic [255:0] cap_line;
    logic [3:0]   cap_way;
    logic [31:0]  last_base = 32'h8000_0040;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // A line is split into four 8-byte beats, lowest slice first, from the 32-byte-aligned base.
    function automatic void push_line(logic [31:0] adr, logic [255:0] line, logic [3:0] way);
        logic [31:0] base;
        base = adr & ~32'd31;
        for (int b = 0; b < 4; b++) begin
            beat_t e;
            e.base = base;
            e.adr  = base + 32'(b * 8);
            e.data = line[b*64 +: 64];
            e.last = (b == 3);
            e.way  = way;
            exp_q.push_back(e);
        end
    endfunction

    // Inputs change 1ns after posedge; a new line is accepted only if nothing is in flight.
    task automatic drive_cycle(input bit ev, input logic [31:0] adr, input logic [255:0] line,
                               input logic [3:0] way, input bit ack, input logic [31:0] lk);
        @(posedge clk);
        #1;
        if (cap_pending) begin
            push_line(cap_adr, cap_line, cap_way);
            last_base   = cap_adr & ~32'd31;
            cap_pending = 1'b0;
        end
        EvictValid = ev;
        EvictAdr   = adr;
        EvictLine  = line;
        EvictWay   = way;
        BusBeatAck = ack;
        LookupAdr  = lk;
        if (ev && exp_q.size() == 0) begin
            cap_pending = 1'b1;
            cap_adr     = adr;
            cap_line    = line;
            cap_way     = way;
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] rand_lookup();
        if ($urandom_range(0, 1) == 1) return last_base + 32'($urandom_range(0, 63));
        return $urandom;
    endfunction

    // Monitor: checks every non-reset cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                chk("evict_ready", EvictReady, exp_q.size() == 0);
                chk("bus_req", BusReq, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("bus_adr", BusAdr, exp_q[0].adr);
                    chk("bus_wdata", BusWData, exp_q[0].data);
                    chk("bus_last", BusLast, exp_q[0].last);
                    chk("held_way", HeldWay, exp_q[0].way);
                    chk("lookup_hit", LookupHit, LookupAdr[31:5] == exp_q[0].base[31:5]);
                    chk("wb_done", WbDone, BusBeatAck && exp_q[0].last);
                    if (WbDone) n_done++;
                    if (BusBeatAck) void'(exp_q.pop_front());
                end else begin
                    chk("bus_last_idle", BusLast, 1'b0);
                    chk("lookup_hit_idle", LookupHit, 1'b0);
                    chk("wb_done_idle", WbDone, 1'b0);
                end
            end
        end
    end

    initial begin
        logic [255:0] dline;
        int           done_before;
        int           wait_cnt;
        bit           ack_pat[8];
        reset      = 1'b1;
        EvictValid = 1'b0;
        EvictAdr   = '0;
        EvictLine  = '0;
        EvictWay   = '0;
        BusBeatAck = 1'b0;
        LookupAdr  = '0;
        #2;
        chk("rst_evict_ready", EvictReady, 1'b1);
        chk("rst_bus_req", BusReq, 1'b0);
        chk("rst_bus_last", BusLast, 1'b0);
        chk("rst_lookup_hit", LookupHit, 1'b0);
        chk("rst_wb_done", WbDone, 1'b0);
        chk("rst_held_way", HeldWay, 4'b0000);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_reset = 1'b0;

        // Single line, continuous ack, lookups straddling the line boundary.
        dline = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        drive_cycle(1'b1, 32'h8000_0047, dline, 4'b0100, 1'b0, 32'h8000_005F);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_005F);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_0060);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_005F);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_0040);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 32'h8000_0040);
        chk("single_line_done", n_done, 1);

        // Stalled bus with a second line offered throughout the first drain.
        ack_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        done_before = n_done;
        drive_cycle(1'b1, 32'h1234_5678, rand_line(), 4'b0010, 1'b0, 32'h1234_5660);
        for (int i = 0; i < 8; i++)
            drive_cycle(1'b1, 32'hABCD_0000, rand_line(), 4'b1000, ack_pat[i], rand_lookup());
        drive_cycle(1'b1, 32'hABCD_0010, rand_line(), 4'b1000, 1'b0, rand_lookup());
        drive_cycle(1'b0, '0, '0, '0, 1'b0, rand_lookup());
        chk("stall_one_done", n_done - done_before, 1);

        // Randomized traffic: frequent offers, random acks and lookups.
        for (int c = 0; c < 600; c++)
            drive_cycle($urandom_range(0, 2) != 0, $urandom, rand_line(),
                        4'(1 << $urandom_range(0, 3)), $urandom_range(0, 1) == 1, rand_lookup());

        wait_cnt = 0;
        while ((exp_q.size() != 0 || cap_pending) && wait_cnt < 40) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, rand_lookup());
            wait_cnt++;
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b0, '0);
        chk("drain_timeout", exp_q.size(), 0);

        // Reset in the middle of a drain after beat 1 has been acked.
        done_before = n_done;
        drive_cycle(1'b1, 32'h8000_0040, rand_line(), 4'b0001, 1'b0, 32'h8000_0050);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_0050);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_0050);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 32'h8000_0050);
        @(posedge clk);
        #1;
        in_reset    = 1'b1;
        reset       = 1'b1;
        BusBeatAck  = 1'b1;
        #1;
        chk("mid_rst_bus_req", BusReq, 1'b0);
        chk("mid_rst_evict_ready", EvictReady, 1'b1);
        chk("mid_rst_lookup_hit", LookupHit, 1'b0);
        chk("mid_rst_wb_done", WbDone, 1'b0);
        chk("mid_rst_held_way", HeldWay, 4'b0000);
        exp_q.delete();
        cap_pending = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        BusBeatAck = 1'b0;
        in_reset   = 1'b0;
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 32'h8000_0050);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 32'h8000_0050);
        chk("mid_rst_no_done", n_done - done_before, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
